macro_cmd_dispatcher: RTL and testbench

MACRO_CMD_DISPATCHER -- requirements
Module: macro_cmd_dispatcher

---
 rtl/macro_cmd_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_macro_cmd_dispatcher.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macro_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// macro_cmd_dispatcher
// Buffers host instructions in a small FIFO and dispatches them to a memory
// macro. STORE/LOAD become one-cycle ExLdSt commands on a shared tristate
// data bus. COMPUTE is parked in a one-entry slot that is held until the
// macro accepts it. FENCE waits for the compute slot and the ExLdSt port to
// go quiet before it retires.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   host_valid/host_ready    instruction handshake, host_instr[31:0]
//   ExLdSt_valid/command     one-cycle load/store command {wr, addr[5:0]}
//   ExLdSt_data              shared bus, driven only for STORE
//   Compute_valid/ready      compute handshake, Compute_command[24:0]
//   rsp_valid/addr/data      one-cycle LOAD response
//   busy                     work pending anywhere in the dispatcher
// ---------------------------------------------------------------------------
module macro_cmd_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_NUM    = 16,
    parameter int ADDR_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [31:0]        host_instr,
    output logic               ExLdSt_valid,
    output logic [6:0]         ExLdSt_command,
    inout  wire  [ROW_NUM-1:0] ExLdSt_data,
    output logic               Compute_valid,
    input  logic               Compute_ready,
    output logic [24:0]        Compute_command,
    output logic               rsp_valid,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic [ROW_NUM-1:0] rsp_data,
    output logic               busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    localparam logic [1:0] OP_STORE   = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_COMPUTE = 2'b10;
    localparam logic [1:0] OP_FENCE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_STALL = 2'b10
    } state_e;

    // Entry keeps only the opcode and the 25 payload bits; [29:25] are reserved.
    logic [26:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic [26:0]        head_s;
    logic [1:0]         head_op_s;
    logic               head_issuable_s, slot_release_s;
    state_e             state_q, state_d;
    logic               host_ready_q, host_ready_d;
    logic               ex_valid_q, ex_valid_d;
    logic [6:0]         ex_cmd_q, ex_cmd_d;
    logic [ROW_NUM-1:0] ex_wdata_q, ex_wdata_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [24:0]        cmp_cmd_q, cmp_cmd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic [ROW_NUM-1:0] rsp_data_q, rsp_data_d;
    logic               unused_rsvd_s;

    // Reserved instruction bits carry no meaning for the dispatcher.
    assign unused_rsvd_s = ^host_instr[29:25];

    // Pointers carry one extra wrap bit: equal -> empty, only wrap bit differs -> full.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // host_ready_q tracks !fifo_full_s; the extra term keeps a push impossible when full.
    assign push_s       = host_valid && host_ready_q && !fifo_full_s;
    assign head_s       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_op_s    = head_s[26:25];
    assign slot_release_s = cmp_valid_q && Compute_ready;

    // Decide whether the head instruction can retire on this edge.
    always_comb begin
        head_issuable_s = 1'b0;
        case (head_op_s)
            OP_STORE:   head_issuable_s = 1'b1;
            OP_LOAD:    head_issuable_s = 1'b1;
            // A COMPUTE may reuse the slot on the same edge the macro frees it.
            OP_COMPUTE: head_issuable_s = !cmp_valid_q || Compute_ready;
            // A FENCE needs the slot truly empty and no ExLdSt command on the port.
            OP_FENCE:   head_issuable_s = !cmp_valid_q && !ex_valid_q;
            default:    head_issuable_s = 1'b0;
        endcase
    end

    assign pop_s = (state_q != ST_IDLE) && !fifo_empty_s && head_issuable_s;

    // Pointer, FSM and host_ready next-state computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_ptr_d == rd_ptr_d) begin
            state_d = ST_IDLE;
        end else if (!fifo_empty_s && !pop_s) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ISSUE;
        end
        host_ready_d = !((wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                         (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]));
    end

    // Output next-state: ExLdSt command, compute slot and LOAD response.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_cmd_d    = 7'b0;
        ex_wdata_d  = {ROW_NUM{1'b0}};
        cmp_valid_d = cmp_valid_q;
        cmp_cmd_d   = cmp_cmd_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        if (pop_s && (head_op_s == OP_STORE)) begin
            ex_valid_d = 1'b1;
            ex_cmd_d   = {1'b1, head_s[21:16]};
            ex_wdata_d = ROW_NUM'(head_s[15:0]);
        end else if (pop_s && (head_op_s == OP_LOAD)) begin
            ex_valid_d = 1'b1;
            ex_cmd_d   = {1'b0, head_s[21:16]};
        end else begin
            ex_valid_d = 1'b0;
        end
        if (pop_s && (head_op_s == OP_COMPUTE)) begin
            cmp_valid_d = 1'b1;
            cmp_cmd_d   = head_s[24:0];
        end else if (slot_release_s) begin
            cmp_valid_d = 1'b0;
            cmp_cmd_d   = 25'b0;
        end else begin
            cmp_valid_d = cmp_valid_q;
        end
        // LOAD data is on the bus during the ExLdSt cycle; capture it at its closing edge.
        rsp_valid_d = ex_valid_q && !ex_cmd_q[6];
        if (rsp_valid_d) begin
            rsp_addr_d = ADDR_W'(ex_cmd_q[5:0]);
            rsp_data_d = ExLdSt_data;
        end else begin
            rsp_addr_d = rsp_addr_q;
        end
    end

    // Instruction storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {host_instr[31:30], host_instr[24:0]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= {(PTR_W+1){1'b0}};
            rd_ptr_q     <= {(PTR_W+1){1'b0}};
            state_q      <= ST_IDLE;
            host_ready_q <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_cmd_q     <= 7'b0;
            ex_wdata_q   <= {ROW_NUM{1'b0}};
            cmp_valid_q  <= 1'b0;
            cmp_cmd_q    <= 25'b0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= {ADDR_W{1'b0}};
            rsp_data_q   <= {ROW_NUM{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            host_ready_q <= host_ready_d;
            ex_valid_q   <= ex_valid_d;
            ex_cmd_q     <= ex_cmd_d;
            ex_wdata_q   <= ex_wdata_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_cmd_q    <= cmp_cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign host_ready      = host_ready_q;
    assign ExLdSt_valid    = ex_valid_q;
    assign ExLdSt_command  = ex_cmd_q;
    assign ExLdSt_data     = (ex_valid_q && ex_cmd_q[6]) ? ex_wdata_q : {ROW_NUM{1'bz}};
    assign Compute_valid   = cmp_valid_q;
    assign Compute_command = cmp_cmd_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_addr        = rsp_addr_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = !fifo_empty_s || cmp_valid_q || ex_valid_q;

endmodule

// File: tb/tb_macro_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// Self-checking bench for macro_cmd_dispatcher. A behavioural macro model
// answers LOADs from its own memory; a scoreboard holds the expected ExLdSt
// commands, LOAD responses and compute commands in issue order.
// ---------------------------------------------------------------------------
module tb_macro_cmd_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_instr;
    logic        ExLdSt_valid;
    logic [6:0]  ExLdSt_command;
    wire  [15:0] exld_data;
    logic        Compute_valid;
    logic        Compute_ready;
    logic [24:0] Compute_command;
    logic        rsp_valid;
    logic [5:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        busy;

    int n_checks;
    int n_errors;

    macro_cmd_dispatcher #(.FIFO_DEPTH(4), .ROW_NUM(16), .ADDR_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_instr      (host_instr),
        .ExLdSt_valid    (ExLdSt_valid),
        .ExLdSt_command  (ExLdSt_command),
        .ExLdSt_data     (exld_data),
        .Compute_valid   (Compute_valid),
        .Compute_ready   (Compute_ready),
        .Compute_command (Compute_command),
        .rsp_valid       (rsp_valid),
        .rsp_addr        (rsp_addr),
        .rsp_data        (rsp_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: drives read data during a LOAD cycle, captures STORE data.
    logic [15:0] macro_mem [64];
    assign exld_data = (ExLdSt_valid && !ExLdSt_command[6]) ? macro_mem[ExLdSt_command[5:0]] : 16'bz;
    always @(posedge clk) begin
        if (ExLdSt_valid && ExLdSt_command[6]) macro_mem[ExLdSt_command[5:0]] <= exld_data;
    end

    // Scoreboard queues.
    typedef struct { logic [6:0] cmd; logic [15:0] data; } ex_exp_t;
    typedef struct { logic [5:0] addr; logic [15:0] data; } rsp_exp_t;
    ex_exp_t     ex_q [$];
    rsp_exp_t    rsp_q [$];
    logic [24:0] cmp_q [$];
    logic [15:0] shadow [64];

    typedef struct {
        logic [31:0] instr;
        bit          has_ex;
        logic [6:0]  ex_cmd;
        logic [15:0] ex_data;
        bit          has_rsp;
        logic [5:0]  rsp_addr;
        logic [15:0] rsp_data;
        bit          has_cmp;
        logic [24:0] cmp_cmd;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] st_i(input logic [5:0] a, input logic [15:0] d);
        return {2'b00, 8'h00, a, d};
    endfunction
    function automatic logic [31:0] ld_i(input logic [5:0] a);
        return {2'b01, 8'h00, a, 16'h0000};
    endfunction
    function automatic logic [31:0] cp_i(input logic [24:0] c);
        return {2'b10, 5'b00000, c};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        ex_exp_t  e;
        rsp_exp_t r;
        logic [24:0] c;
        if (rst_n) begin
            if (ExLdSt_valid) begin
                if (ex_q.size() == 0) begin
                    check("exld_unexpected", 32'(ExLdSt_command), 32'hFFFF_FFFF);
                end else begin
                    e = ex_q.pop_front();
                    check("exld_cmd", 32'(ExLdSt_command), 32'(e.cmd));
                    if (e.cmd[6]) check("exld_wdata", 32'(exld_data), 32'(e.data));
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_addr), 32'hFFFF_FFFF);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_addr", 32'(rsp_addr), 32'(r.addr));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                end
            end
            if (Compute_valid && Compute_ready) begin
                if (cmp_q.size() == 0) begin
                    check("cmp_unexpected", 32'(Compute_command), 32'hFFFF_FFFF);
                end else begin
                    c = cmp_q.pop_front();
                    check("cmp_cmd", 32'(Compute_command), 32'(c));
                end
            end
        end
    end

    // Push one instruction; optionally derive scoreboard entries from it.
    task automatic push(input logic [31:0] ins, input bit auto_exp);
        int n;
        ex_exp_t  e;
        rsp_exp_t r;
        n = 0;
        host_valid = 1'b1;
        host_instr = ins;
        while (!host_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!host_ready) begin
            check("push_timeout", 32'(host_ready), 32'd1);
            host_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        host_valid = 1'b0;
        if (auto_exp) begin
            case (ins[31:30])
                2'b00: begin
                    e.cmd = {1'b1, ins[21:16]}; e.data = ins[15:0];
                    ex_q.push_back(e);
                    shadow[ins[21:16]] = ins[15:0];
                end
                2'b01: begin
                    e.cmd = {1'b0, ins[21:16]}; e.data = 16'h0000;
                    ex_q.push_back(e);
                    r.addr = ins[21:16]; r.data = shadow[ins[21:16]];
                    rsp_q.push_back(r);
                end
                2'b10: cmp_q.push_back(ins[24:0]);
                default: ;
            endcase
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((ex_q.size() + rsp_q.size() + cmp_q.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(ex_q.size() + rsp_q.size() + cmp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] c1, c2;
        ex_exp_t  e;
        rsp_exp_t r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; host_valid = 1'b0; host_instr = 32'h0; Compute_ready = 1'b1;
        c1 = 25'b0_010_010_000001_000010_000011;
        c2 = {1'b0, 3'b011, 3'b001, 6'd1, 6'd2, 6'd5};   // MUL, rd=5

        vecs[0] = '{st_i(6'd5, 16'h1234),                  1'b1, 7'h45, 16'h1234, 1'b0, 6'd0,  16'h0,    1'b0, 25'h0};
        vecs[1] = '{st_i(6'd63, 16'hFFFF),                 1'b1, 7'h7F, 16'hFFFF, 1'b0, 6'd0,  16'h0,    1'b0, 25'h0};
        vecs[2] = '{{2'b01, 8'h00, 6'd5, 16'hDEAD},        1'b1, 7'h05, 16'h0,    1'b1, 6'd5,  16'h1234, 1'b0, 25'h0};
        vecs[3] = '{{2'b10, 5'b10101, 25'h1ABCDEF},        1'b0, 7'h00, 16'h0,    1'b0, 6'd0,  16'h0,    1'b1, 25'h1ABCDEF};
        vecs[4] = '{ld_i(6'd63),                           1'b1, 7'h3F, 16'h0,    1'b1, 6'd63, 16'hFFFF, 1'b0, 25'h0};
        vecs[5] = '{{2'b11, 30'h0},                        1'b0, 7'h00, 16'h0,    1'b0, 6'd0,  16'h0,    1'b0, 25'h0};
        vecs[6] = '{{2'b00, 8'hA5, 6'd0, 16'h0001},        1'b1, 7'h40, 16'h0001, 1'b0, 6'd0,  16'h0,    1'b0, 25'h0};
        vecs[7] = '{ld_i(6'd0),                            1'b1, 7'h00, 16'h0,    1'b1, 6'd0,  16'h0001, 1'b0, 25'h0};

        // Reset values.
        #2;
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_exld_valid", 32'(ExLdSt_valid), 32'd0);
        check("rst_exld_cmd", 32'(ExLdSt_command), 32'd0);
        check("rst_cmp_valid", 32'(Compute_valid), 32'd0);
        check("rst_cmp_cmd", 32'(Compute_command), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_addr, rsp_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(host_ready), 32'd1);

        // Latency: handshake at E0 -> ExLdSt_valid in the cycle after E1.
        push(st_i(6'd3, 16'h5A5A), 1'b1);
        @(negedge clk);
        check("lat_e0_valid", 32'(ExLdSt_valid), 32'd0);
        @(negedge clk);
        check("lat_e1_valid", 32'(ExLdSt_valid), 32'd1);
        check("lat_e1_cmd", 32'(ExLdSt_command), 32'h43);
        check("lat_e1_bus", 32'(exld_data), 32'h5A5A);
        drain("lat_drain");

        // STORE then LOAD back-to-back through the macro model.
        push(st_i(6'd1, 16'hAA55), 1'b1);
        push(ld_i(6'd1), 1'b1);
        @(negedge clk);
        check("sl_st_cmd", 32'(ExLdSt_command), 32'h41);
        check("sl_st_bus", 32'(exld_data), 32'hAA55);
        @(negedge clk);
        check("sl_ld_valid", 32'(ExLdSt_valid), 32'd1);
        check("sl_ld_cmd", 32'(ExLdSt_command), 32'h01);
        check("sl_ld_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("sl_rsp_valid", 32'(rsp_valid), 32'd1);
        check("sl_rsp_addr", 32'(rsp_addr), 32'd1);
        check("sl_rsp_data", 32'(rsp_data), 32'hAA55);
        check("sl_exld_idle", 32'(ExLdSt_valid), 32'd0);
        drain("sl_drain");

        // Table-driven vectors, expectations from the table itself.
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].instr, 1'b0);
            if (vecs[i].has_ex) begin
                e.cmd = vecs[i].ex_cmd; e.data = vecs[i].ex_data;
                ex_q.push_back(e);
            end
            if (vecs[i].has_rsp) begin
                r.addr = vecs[i].rsp_addr; r.data = vecs[i].rsp_data;
                rsp_q.push_back(r);
            end
            if (vecs[i].has_cmp) cmp_q.push_back(vecs[i].cmp_cmd);
        end
        drain("tbl_drain");

        // Compute held for 3 not-ready cycles -> valid 4 cycles.
        Compute_ready = 1'b0;
        push(cp_i(c1), 1'b1);
        @(negedge clk);
        check("hold_pre_valid", 32'(Compute_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(Compute_valid), 32'd1);
            check("hold_cmd", 32'(Compute_command), 32'(c1));
            if (i == 2) begin
                @(posedge clk); #1;
                Compute_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("hold_released", 32'(Compute_valid), 32'd0);
        check("hold_cmd_idle", 32'(Compute_command), 32'd0);
        drain("hold_drain");

        // LOAD overlaps a waiting compute; second compute follows with no bubble.
        Compute_ready = 1'b0;
        push(cp_i(c1), 1'b1);
        push(ld_i(6'd3), 1'b1);
        push(cp_i(c2), 1'b1);
        @(negedge clk);
        check("ovl_ld_valid", 32'(ExLdSt_valid), 32'd1);
        check("ovl_ld_cmd", 32'(ExLdSt_command), 32'h03);
        check("ovl_cmp_cmd", 32'(Compute_command), 32'(c1));
        repeat (2) begin
            @(negedge clk);
            check("ovl_stall_cmd", 32'(Compute_command), 32'(c1));
        end
        @(posedge clk); #1;
        Compute_ready = 1'b1;
        @(posedge clk); #1;
        Compute_ready = 1'b0;
        @(negedge clk);
        check("b2b_valid", 32'(Compute_valid), 32'd1);
        check("b2b_cmd", 32'(Compute_command), 32'(c2));
        @(posedge clk); #1;
        Compute_ready = 1'b1;
        drain("ovl_drain");

        // FENCE holds the LOAD until the compute is accepted.
        Compute_ready = 1'b0;
        push(cp_i(c2), 1'b1);
        push({2'b11, 30'h0}, 1'b1);
        push(ld_i(6'd3), 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("fence_hold_ld", 32'(ExLdSt_valid), 32'd0);
        end
        @(posedge clk); #1;
        Compute_ready = 1'b1;
        @(posedge clk); #1;
        Compute_ready = 1'b0;
        @(negedge clk);
        check("fence_slot_free", 32'(Compute_valid), 32'd0);
        check("fence_pop_cycle", 32'(ExLdSt_valid), 32'd0);
        @(negedge clk);
        check("fence_gap", 32'(ExLdSt_valid), 32'd0);
        @(negedge clk);
        check("fence_ld_valid", 32'(ExLdSt_valid), 32'd1);
        check("fence_ld_cmd", 32'(ExLdSt_command), 32'h03);
        drain("fence_drain");

        // FIFO full behind a stalled COMPUTE; push blocked on the pop edge.
        Compute_ready = 1'b0;
        push(cp_i(c1), 1'b1);
        push(cp_i(c2), 1'b1);
        push(st_i(6'd10, 16'h0A0A), 1'b1);
        push(st_i(6'd11, 16'h0B0B), 1'b1);
        push(ld_i(6'd10), 1'b1);
        host_valid = 1'b1;
        host_instr = st_i(6'd12, 16'h0C0C);
        repeat (3) begin
            @(negedge clk);
            check("full_ready_low", 32'(host_ready), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        Compute_ready = 1'b1;
        @(negedge clk);
        check("full_pop_edge_ready", 32'(host_ready), 32'd0);
        push(st_i(6'd12, 16'h0C0C), 1'b1);
        push(ld_i(6'd12), 1'b1);
        drain("full_drain");

        // Reset mid-operation drops everything.
        Compute_ready = 1'b0;
        push(cp_i(c1), 1'b1);
        push(cp_i(c2), 1'b1);
        push(st_i(6'd20, 16'h2020), 1'b1);
        push(st_i(6'd21, 16'h2121), 1'b1);
        @(negedge clk);
        check("mid_cmp_valid", 32'(Compute_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmp_valid", 32'(Compute_valid), 32'd0);
        check("mid_rst_cmp_cmd", 32'(Compute_command), 32'd0);
        check("mid_rst_exld", 32'({ExLdSt_valid, ExLdSt_command}), 32'd0);
        check("mid_rst_rsp", 32'({rsp_valid, rsp_addr, rsp_data}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(host_ready), 32'd0);
        ex_q.delete();
        rsp_q.delete();
        cmp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_ready", 32'(host_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("rel_no_issue", 32'({busy, ExLdSt_valid, Compute_valid}), 32'd0);
        end
        Compute_ready = 1'b1;
        push(ld_i(6'd1), 1'b1);
        drain("rel_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
